// File: rtl/systolic_matmul_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : systolic_matmul_ctrl
// Brief    : N x N output-stationary systolic matmul with internal skew/control.
//            Optional macro SYSTOLIC_MATMUL_ACCUMULATE_EN adds i_accumulate.
// Revision : 1.0
// ============================================================================
module systolic_matmul_ctrl #(
    parameter  int N     = 4,
    parameter  int W     = 8,
    localparam int ACC_W = 2*W + $clog2(N)
) (
    input  logic                           i_clk,
    input  logic                           i_srst,
    input  logic                           i_start,
    input  logic                           i_signed,
`ifdef SYSTOLIC_MATMUL_ACCUMULATE_EN
    input  logic                           i_accumulate,
`endif
    input  logic [N-1:0][N-1:0][W-1:0]     i_a,
    input  logic [N-1:0][N-1:0][W-1:0]     i_b,
    output logic                           o_busy,
    output logic                           o_valid,
    output logic [N-1:0][N-1:0][ACC_W-1:0] o_c
);
    localparam int            KW     = $clog2(3*N-2);
    localparam logic [KW-1:0] LAST_K = KW'(3*N-3);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                         r_state;
    logic [KW-1:0]                  r_k;
    logic                           r_signed;
    logic [N-1:0][N-1:0][W-1:0]     r_a;
    logic [N-1:0][N-1:0][W-1:0]     r_b;
    logic [N-1:0][W-1:0]            w_inj_a;
    logic [N-1:0][W-1:0]            w_inj_b;
    logic [N-1:0][N-1:0][W-1:0]     w_a_in;
    logic [N-1:0][N-1:0][W-1:0]     w_b_in;
    logic [N-1:0][N-2:0][W-1:0]     r_a_pipe;
    logic [N-2:0][N-1:0][W-1:0]     r_b_pipe;
    logic [N-1:0][N-1:0][ACC_W-1:0] r_acc;
    logic [N-1:0][N-1:0][ACC_W-1:0] w_prod;
    logic                           w_start;
    logic                           w_clear;

    // Operands widened to ACC_W; the low ACC_W bits of the product are exact
    // in both modes, which is all a modular accumulator needs.
    function automatic logic [ACC_W-1:0] ext(input logic [W-1:0] v, input logic s);
        return {{(ACC_W-W){s & v[W-1]}}, v};
    endfunction

    assign w_start = i_start && (r_state != S_RUN);
`ifdef SYSTOLIC_MATMUL_ACCUMULATE_EN
    assign w_clear = w_start && !i_accumulate;
`else
    assign w_clear = w_start;
`endif

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_state  <= S_IDLE;
            r_k      <= '0;
            r_signed <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            o_busy   <= 1'b0;
            o_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (r_k == LAST_K) begin
                        r_state <= S_DONE;
                        o_busy  <= 1'b0;
                        o_valid <= 1'b1;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                default: begin
                    if (i_start) begin
                        r_state  <= S_RUN;
                        r_k      <= '0;
                        r_signed <= i_signed;
                        r_a      <= i_a;
                        r_b      <= i_b;
                        o_busy   <= 1'b1;
                        o_valid  <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Diagonal skew: row i starts i cycles late, column j starts j cycles late.
    always_comb begin
        w_inj_a = '0;
        w_inj_b = '0;
        for (int i = 0; i < N; i++) begin
            for (int m = 0; m < N; m++) begin
                if (r_k == KW'(i + m)) w_inj_a[i] = r_a[i][m];
                if (r_k == KW'(i + m)) w_inj_b[i] = r_b[m][i];
            end
        end
    end

    always_comb begin
        w_a_in = '0;
        w_b_in = '0;
        for (int i = 0; i < N; i++) begin
            w_a_in[i][0] = w_inj_a[i];
            w_b_in[0][i] = w_inj_b[i];
            for (int j = 1; j < N; j++) begin
                w_a_in[i][j] = r_a_pipe[i][j-1];
                w_b_in[j][i] = r_b_pipe[j-1][i];
            end
        end
    end

    always_comb begin
        w_prod = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                w_prod[i][j] = ext(w_a_in[i][j], r_signed) * ext(w_b_in[i][j], r_signed);
            end
        end
    end

    // Pipelines are flushed at start so stale operands never reach a fresh pass.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_a_pipe <= '0;
            r_b_pipe <= '0;
            r_acc    <= '0;
        end else if (w_start) begin
            r_a_pipe <= '0;
            r_b_pipe <= '0;
            if (w_clear) r_acc <= '0;
        end else if (r_state == S_RUN) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    r_acc[i][j] <= r_acc[i][j] + w_prod[i][j];
                end
                for (int j = 0; j < N-1; j++) begin
                    r_a_pipe[i][j] <= w_a_in[i][j];
                    r_b_pipe[j][i] <= w_b_in[j][i];
                end
            end
        end
    end

    assign o_c = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_systolic_matmul_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_matmul_ctrl
// Brief    : Directed + random self-checking bench against a plain-arithmetic model.
// Revision : 1.0
// ============================================================================
module tb_systolic_matmul_ctrl;
    localparam int N     = 4;
    localparam int W     = 8;
    localparam int ACC_W = 2*W + $clog2(N);

    typedef logic [N-1:0][N-1:0][W-1:0]     mat_t;
    typedef logic [N-1:0][N-1:0][ACC_W-1:0] res_t;

    logic clk = 1'b0;
    logic srst, start, sgn, busy, valid;
    mat_t a, b;
    res_t c;
`ifdef SYSTOLIC_MATMUL_ACCUMULATE_EN
    logic accum;
`endif

    int   checks = 0;
    int   errors = 0;
    res_t exp_c;

    always #5 clk = ~clk;

    systolic_matmul_ctrl #(.N(N), .W(W)) dut (
        .i_clk        (clk),
        .i_srst       (srst),
        .i_start      (start),
        .i_signed     (sgn),
`ifdef SYSTOLIC_MATMUL_ACCUMULATE_EN
        .i_accumulate (accum),
`endif
        .i_a          (a),
        .i_b          (b),
        .o_busy       (busy),
        .o_valid      (valid),
        .o_c          (c)
    );

    function automatic res_t model(mat_t ma, mat_t mb, logic s, res_t base);
        res_t   r;
        longint sum, x, y;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                sum = longint'(base[i][j]);
                for (int k = 0; k < N; k++) begin
                    x = s ? longint'($signed(ma[i][k])) : longint'(ma[i][k]);
                    y = s ? longint'($signed(mb[k][j])) : longint'(mb[k][j]);
                    sum += x * y;
                end
                r[i][j] = sum[ACC_W-1:0];
            end
        end
        return r;
    endfunction

    function automatic mat_t rand_mat();
        mat_t m;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                m[i][j] = W'($urandom);
        return m;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_c(input string tag);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                check($sformatf("%s c[%0d][%0d]", tag, i, j), 64'(c[i][j]), 64'(exp_c[i][j]));
    endtask

    // Returns at the falling edge right after the accepting clock edge.
    task automatic start_pass(input mat_t xa, input mat_t xb, input logic s, input logic acc);
        @(negedge clk);
        a = xa; b = xb; sgn = s; start = 1'b1;
`ifdef SYSTOLIC_MATMUL_ACCUMULATE_EN
        accum = acc;
`endif
        exp_c = model(xa, xb, s, acc ? exp_c : res_t'(0));
        @(negedge clk);
        start = 1'b0; a = rand_mat(); b = rand_mat(); sgn = 1'($urandom);
    endtask

    task automatic wait_valid(input int pulse_at, output int cyc, output int bcyc);
        cyc  = 0;
        bcyc = int'(busy);
        while (!valid && cyc < 40) begin
            if (cyc == pulse_at) begin
                start = 1'b1; a = rand_mat(); b = rand_mat();
            end
            @(negedge clk);
            start = 1'b0;
            cyc++;
            bcyc += int'(busy);
        end
    endtask

    task automatic full_pass(input string tag, input mat_t xa, input mat_t xb,
                             input logic s, input logic acc);
        int cyc, bcyc;
        start_pass(xa, xb, s, acc);
        check({tag, " busy after start"}, 64'(busy), 64'(1));
        check({tag, " valid drops"}, 64'(valid), 64'(0));
        wait_valid(-1, cyc, bcyc);
        check({tag, " latency"}, 64'(cyc), 64'(3*N-2));
        check({tag, " busy cycles"}, 64'(bcyc), 64'(3*N-2));
        check_c(tag);
    endtask

    initial begin
        mat_t ident, ramp, ma, mb;
        int   cyc, bcyc;
        logic saw;

        srst = 1'b1; start = 1'b0; sgn = 1'b0; a = '0; b = '0; exp_c = '0;
`ifdef SYSTOLIC_MATMUL_ACCUMULATE_EN
        accum = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset busy", 64'(busy), 64'(0));
        check("reset valid", 64'(valid), 64'(0));
        check("reset c zero", 64'(|c), 64'(0));
        srst = 1'b0;

        ident = '0;
        for (int i = 0; i < N; i++) ident[i][i] = W'(1);
        for (int k = 0; k < N; k++)
            for (int j = 0; j < N; j++) ramp[k][j] = W'(4*k + j);
        full_pass("identity", ident, ramp, 1'b0, 1'b0);
        check("identity c[2][3]", 64'(c[2][3]), 64'(11));

        repeat (5) @(negedge clk);
        check("done holds valid", 64'(valid), 64'(1));
        check_c("done hold");

        full_pass("max unsigned", mat_t'({N*N{8'hFF}}), mat_t'({N*N{8'hFF}}), 1'b0, 1'b0);
        check("max unsigned c[1][2]", 64'(c[1][2]), 64'(260100));
        full_pass("signed -128", mat_t'({N*N{8'h80}}), mat_t'({N*N{8'h80}}), 1'b1, 1'b0);
        check("signed -128 c[3][0]", 64'(c[3][0]), 64'(65536));
        full_pass("signed mix", mat_t'({N*N{8'h80}}), mat_t'({N*N{8'h7F}}), 1'b1, 1'b0);
        check("signed mix c[0][1]", 64'(c[0][1]), 64'(18'h30200));

        for (int t = 0; t < 6; t++)
            full_pass($sformatf("random%0d", t), rand_mat(), rand_mat(), 1'((t % 2 == 1)), 1'b0);

        // Start request mid-run must be ignored.
        ma = rand_mat(); mb = rand_mat();
        start_pass(ma, mb, 1'b1, 1'b0);
        wait_valid(3, cyc, bcyc);
        check("midrun start latency", 64'(cyc), 64'(3*N-2));
        check_c("midrun start");

        // Reset mid-run aborts the pass.
        start_pass(rand_mat(), rand_mat(), 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        check("abort busy", 64'(busy), 64'(0));
        check("abort valid", 64'(valid), 64'(0));
        check("abort c zero", 64'(|c), 64'(0));
        saw = 1'b0;
        repeat (15) begin
            @(negedge clk);
            saw = saw | valid | busy;
        end
        check("abort stays idle", 64'(saw), 64'(0));

        // Reset wins over a simultaneous start.
        @(negedge clk);
        srst = 1'b1; start = 1'b1; a = rand_mat(); b = rand_mat();
        @(negedge clk);
        srst = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        check("srst+start busy", 64'(busy), 64'(0));
        check("srst+start valid", 64'(valid), 64'(0));

        full_pass("after reset", rand_mat(), rand_mat(), 1'b1, 1'b0);

`ifdef SYSTOLIC_MATMUL_ACCUMULATE_EN
        full_pass("acc base", ident, ident, 1'b0, 1'b0);
        full_pass("acc add", ident, ident, 1'b0, 1'b1);
        check("acc diag two", 64'(c[1][1]), 64'(2));
        check("acc offdiag zero", 64'(c[1][2]), 64'(0));
        full_pass("acc clear", ident, ident, 1'b0, 1'b0);
        check("acc diag one", 64'(c[3][3]), 64'(1));
        full_pass("acc rand base", rand_mat(), rand_mat(), 1'b1, 1'b0);
        full_pass("acc rand add", rand_mat(), rand_mat(), 1'b1, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
